axi_lite_intc_multi: RTL and testbench

//  Parametrised AXI4-Lite interrupt controller, successor to the single-bit S_AXI_INTR slave.

---
 rtl/axi_lite_intc_multi.sv | 186 ++++++++++++++++++
 tb/tb_axi_lite_intc_multi.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_intc_multi.sv
// AXI4-Lite interrupt controller: NUM_IRQ synchronised sources with enable, edge/level mode, W1C ack.
// Optional IRQ_HOLDOFF_EN adds a HOLD register that masks irq for HOLD cycles after an ack.
module axi_lite_intc_multi #(
  parameter int unsigned NUM_IRQ            = 8,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned IRQ_ACTIVE_HIGH    = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic [NUM_IRQ-1:0]            irq_src,
  output logic                          irq
);

  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam logic [2:0]  A_GIE  = 3'd0;
  localparam logic [2:0]  A_IER  = 3'd1;
  localparam logic [2:0]  A_IMR  = 3'd2;
  localparam logic [2:0]  A_IAR  = 3'd3;
  localparam logic [2:0]  A_IPR  = 3'd4;
  localparam logic [2:0]  A_ISR  = 3'd5;
`ifdef IRQ_HOLDOFF_EN
  localparam logic [2:0]  A_HOLD = 3'd6;
  localparam logic [2:0]  A_LAST = A_HOLD;
`else
  localparam logic [2:0]  A_LAST = A_ISR;
`endif
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic        IRQ_ON      = (IRQ_ACTIVE_HIGH != 0);
  localparam logic        IRQ_OFF     = ~IRQ_ON;

  logic               r_axi_wr_rdy, r_bvalid, r_arready, r_rvalid, r_irq, r_gie;
  logic [1:0]         r_bresp, r_rresp;
  logic [DW-1:0]      r_rdata;
  logic [NUM_IRQ-1:0] r_ier, r_imr, r_isr, r_s_d;
  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];

  logic               w_wr_en, w_rd_en, w_irq_act, w_unused;
  logic [2:0]         w_waddr, w_raddr;
  logic [DW-1:0]      w_bmask, w_rdata;
  logic [NUM_IRQ-1:0] w_wmask, w_wbits, w_ack, w_s, w_set, w_pend;

  assign w_wr_en = r_axi_wr_rdy & s_axi_awvalid & s_axi_wvalid;
  assign w_rd_en = r_arready & s_axi_arvalid;
  assign w_waddr = s_axi_awaddr[4:2];
  assign w_raddr = s_axi_araddr[4:2];
  assign w_bmask = DW'({{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                        {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}});
  assign w_wmask = NUM_IRQ'(w_bmask);
  assign w_wbits = NUM_IRQ'(s_axi_wdata);
  assign w_ack   = (w_wr_en && (w_waddr == A_IAR)) ? (w_wbits & w_wmask) : '0;
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_set   = (r_imr & w_s & ~r_s_d) | (~r_imr & w_s);
  assign w_pend  = r_isr & r_ier;
  assign w_unused = &{1'b0, s_axi_awaddr, s_axi_araddr, s_axi_wdata, w_bmask};

  assign s_axi_awready = r_axi_wr_rdy;
  assign s_axi_wready  = r_axi_wr_rdy;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign irq           = r_irq;

`ifdef IRQ_HOLDOFF_EN
  logic [15:0] r_hold, r_hold_cnt;
  assign w_irq_act = r_gie & (|w_pend) & (r_hold_cnt == 16'd0);
`else
  assign w_irq_act = r_gie & (|w_pend);
`endif

  // Read mux; IAR and unmapped offsets fall through to zero
  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      A_GIE:   w_rdata = DW'(r_gie);
      A_IER:   w_rdata = DW'(r_ier);
      A_IMR:   w_rdata = DW'(r_imr);
      A_IPR:   w_rdata = DW'(w_pend);
      A_ISR:   w_rdata = DW'(r_isr);
`ifdef IRQ_HOLDOFF_EN
      A_HOLD:  w_rdata = DW'(r_hold);
`endif
      default: w_rdata = '0;
    endcase
  end

  // AXI handshakes: ready pulses once per transfer, one response outstanding per channel
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_axi_wr_rdy <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rresp      <= RESP_OKAY;
      r_rdata      <= '0;
    end else begin
      r_axi_wr_rdy <= s_axi_awvalid & s_axi_wvalid & ~r_bvalid & ~r_axi_wr_rdy;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_waddr <= A_LAST) ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= s_axi_arvalid & ~r_rvalid & ~r_arready;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= (w_raddr <= A_LAST) ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Control/status registers and the aggregated irq flop
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_gie <= 1'b0;
      r_ier <= '0;
      r_imr <= '0;
      r_isr <= '0;
      r_irq <= IRQ_OFF;
`ifdef IRQ_HOLDOFF_EN
      r_hold     <= '0;
      r_hold_cnt <= '0;
`endif
    end else begin
      if (w_wr_en) begin
        case (w_waddr)
          A_GIE:  if (s_axi_wstrb[0]) r_gie <= s_axi_wdata[0];
          A_IER:  r_ier <= (r_ier & ~w_wmask) | (w_wbits & w_wmask);
          A_IMR:  r_imr <= (r_imr & ~w_wmask) | (w_wbits & w_wmask);
`ifdef IRQ_HOLDOFF_EN
          A_HOLD: r_hold <= (r_hold & ~w_bmask[15:0]) | (s_axi_wdata[15:0] & w_bmask[15:0]);
`endif
          default: ;
        endcase
      end
      // Set dominates a simultaneous ack
      r_isr <= (r_isr & ~w_ack) | w_set;
      r_irq <= w_irq_act ? IRQ_ON : IRQ_OFF;
`ifdef IRQ_HOLDOFF_EN
      if (|w_ack)
        r_hold_cnt <= r_hold;
      else if (r_hold_cnt != 16'd0)
        r_hold_cnt <= r_hold_cnt - 16'd1;
`endif
    end
  end

  // Source synchroniser and edge-detect history
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_s_d <= '0;
    end else begin
      r_sync[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_s_d <= w_s;
    end
  end

endmodule

// File: tb/tb_axi_lite_intc_multi.sv
// Scoreboard bench for axi_lite_intc_multi: directed AXI accesses, source pulses and irq checks.
module tb_axi_lite_intc_multi;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned SYNC    = 2;
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  logic               ACLK = 1'b0;
  logic               ARESETN = 1'b0;
  logic [4:0]         s_axi_awaddr = '0;
  logic               s_axi_awvalid = 1'b0;
  logic               s_axi_awready;
  logic [31:0]        s_axi_wdata = '0;
  logic [3:0]         s_axi_wstrb = '0;
  logic               s_axi_wvalid = 1'b0;
  logic               s_axi_wready;
  logic [1:0]         s_axi_bresp;
  logic               s_axi_bvalid;
  logic               s_axi_bready = 1'b1;
  logic [4:0]         s_axi_araddr = '0;
  logic               s_axi_arvalid = 1'b0;
  logic               s_axi_arready;
  logic [31:0]        s_axi_rdata;
  logic [1:0]         s_axi_rresp;
  logic               s_axi_rvalid;
  logic               s_axi_rready = 1'b1;
  logic [NUM_IRQ-1:0] irq_src = '0;
  logic               irq;

  axi_lite_intc_multi #(
    .NUM_IRQ(NUM_IRQ), .C_S_AXI_ADDR_WIDTH(5), .C_S_AXI_DATA_WIDTH(32),
    .SYNC_STAGES(SYNC), .IRQ_ACTIVE_HIGH(1)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .irq_src(irq_src), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t    rq[$];
  logic [1:0] bq[$];
  int         checks = 0;
  int         errors = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endfunction

  // Response monitor: pops expectations whenever a response handshake is about to complete
  always @(negedge ACLK) begin
    rd_exp_t    re;
    logic [1:0] eb;
    if (ARESETN) begin
      if (s_axi_bvalid && s_axi_bready) begin
        if (bq.size() == 0) check("unexpected_bresp", 32'd1, 32'd0);
        else begin
          eb = bq.pop_front();
          check("bresp", 32'(s_axi_bresp), 32'(eb));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (rq.size() == 0) check("unexpected_rdata", 32'd1, 32'd0);
        else begin
          re = rq.pop_front();
          check($sformatf("rdata@%02h", re.addr), s_axi_rdata, re.data);
          check($sformatf("rresp@%02h", re.addr), 32'(s_axi_rresp), 32'(re.resp));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic wait_aw();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (s_axi_awready) begin
        ok = 1;
        check("wready_with_awready", 32'(s_axi_wready), 32'd1);
        break;
      end
    end
    @(posedge ACLK);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (!ok) check("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (s_axi_bvalid && s_axi_bready) begin ok = 1; break; end
    end
    @(posedge ACLK);
    #1;
    if (!ok) check("b_timeout", 32'd0, 32'd1);
  endtask

  task automatic aw_issue(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    wait_aw();
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er);
    bq.push_back(er);
    aw_issue(a, d, s);
    wait_b();
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    rd_exp_t e;
    bit ok = 0;
    e.addr = a; e.data = ed; e.resp = er;
    rq.push_back(e);
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (s_axi_arready) begin ok = 1; break; end
    end
    @(posedge ACLK);
    #1;
    s_axi_arvalid = 1'b0;
    if (!ok) check("ar_timeout", 32'd0, 32'd1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (s_axi_rvalid && s_axi_rready) begin ok = 1; break; end
    end
    @(posedge ACLK);
    #1;
    if (!ok) check("r_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_src(input int bit_idx);
    @(posedge ACLK);
    #1 irq_src[bit_idx] = 1'b1;
    @(posedge ACLK);
    #1 irq_src[bit_idx] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int acc;

    // Reset state
    cycles(3);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready", 32'(s_axi_wready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    @(negedge ACLK) ARESETN = 1'b1;
    cycles(1);
    for (int a = 0; a < 6; a++) axi_read(5'(a * 4), 32'd0, OKAY);

    // Edge mode on source 0: latency and W1C ack
    axi_write(5'h00, 32'h1, 4'hF, OKAY);
    axi_write(5'h04, 32'h1, 4'hF, OKAY);
    axi_write(5'h08, 32'h1, 4'hF, OKAY);
    @(posedge ACLK);
    #1 irq_src[0] = 1'b1;
    @(posedge ACLK);
    #1 irq_src[0] = 1'b0;
    n = 1;
    while (irq !== 1'b1 && n < 20) begin
      @(posedge ACLK);
      #1 n++;
    end
    check("edge_irq_latency", 32'(n), 32'(SYNC + 2));
    check("edge_irq_on", 32'(irq), 32'd1);
    axi_read(5'h10, 32'h01, OKAY);
    axi_read(5'h14, 32'h01, OKAY);
    axi_write(5'h0C, 32'h1, 4'hF, OKAY);
    check("edge_irq_off_after_ack", 32'(irq), 32'd0);
    axi_read(5'h10, 32'h00, OKAY);

    // Level mode on source 2: ack while still high re-sets
    axi_write(5'h08, 32'h0, 4'hF, OKAY);
    axi_write(5'h04, 32'h4, 4'hF, OKAY);
    irq_src[2] = 1'b1;
    cycles(5);
    axi_read(5'h14, 32'h04, OKAY);
    check("level_irq_on", 32'(irq), 32'd1);
    axi_write(5'h0C, 32'h4, 4'hF, OKAY);
    axi_read(5'h14, 32'h04, OKAY);
    irq_src[2] = 1'b0;
    cycles(5);
    axi_write(5'h0C, 32'h4, 4'hF, OKAY);
    axi_read(5'h14, 32'h00, OKAY);
    cycles(2);
    check("level_irq_off", 32'(irq), 32'd0);

    // Masking with IER and GIE
    axi_write(5'h04, 32'h0, 4'hF, OKAY);
    pulse_src(5);
    cycles(6);
    axi_read(5'h14, 32'h20, OKAY);
    axi_read(5'h10, 32'h00, OKAY);
    check("masked_irq_off", 32'(irq), 32'd0);
    axi_write(5'h04, 32'h20, 4'hF, OKAY);
    check("unmask_irq_on", 32'(irq), 32'd1);
    axi_write(5'h00, 32'h0, 4'hF, OKAY);
    check("gie_off_irq_off", 32'(irq), 32'd0);
    axi_write(5'h0C, 32'h20, 4'hF, OKAY);
    axi_read(5'h14, 32'h00, OKAY);

    // Decode, strobes and unmapped offsets
    axi_read(5'h1C, 32'h0, SLVERR);
`ifdef IRQ_HOLDOFF_EN
    axi_read(5'h18, 32'h0, OKAY);
`else
    axi_read(5'h18, 32'h0, SLVERR);
`endif
    axi_write(5'h04, 32'hFF, 4'h0, OKAY);
    axi_read(5'h04, 32'h20, OKAY);
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, SLVERR);
    axi_read(5'h00, 32'h0, OKAY);
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, OKAY);
    axi_read(5'h04, 32'hFF, OKAY);
    axi_write(5'h04, 32'h0000_0001, 4'b0010, OKAY);
    axi_read(5'h04, 32'hFF, OKAY);
    axi_write(5'h08, 32'hFFFF_FFA5, 4'b0001, OKAY);
    axi_read(5'h08, 32'hA5, OKAY);
    axi_read(5'h0C, 32'h0, OKAY);

`ifdef IRQ_HOLDOFF_EN
    // Holdoff after ack keeps irq quiet while a new edge is captured
    axi_write(5'h18, 32'd10, 4'hF, OKAY);
    axi_read(5'h18, 32'd10, OKAY);
    axi_write(5'h04, 32'h1, 4'hF, OKAY);
    axi_write(5'h08, 32'h1, 4'hF, OKAY);
    axi_write(5'h00, 32'h1, 4'hF, OKAY);
    pulse_src(0);
    cycles(6);
    check("hold_irq_on", 32'(irq), 32'd1);
    axi_write(5'h0C, 32'h1, 4'hF, OKAY);
    pulse_src(0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (irq !== 1'b0) acc++;
      cycles(1);
    end
    check("hold_irq_quiet", 32'(acc), 32'd0);
    n = 0;
    while (irq !== 1'b1 && n < 20) begin
      cycles(1);
      n++;
    end
    check("hold_irq_release", 32'(irq), 32'd1);
    axi_write(5'h0C, 32'h1, 4'hF, OKAY);
    axi_write(5'h00, 32'h0, 4'hF, OKAY);
`endif

    // Back-pressure on B: no second write accepted while a response is pending
    s_axi_bready = 1'b0;
    bq.push_back(OKAY);
    aw_issue(5'h04, 32'h01, 4'hF);
    bq.push_back(OKAY);
    s_axi_awaddr  = 5'h04;
    s_axi_wdata   = 32'h02;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      if (s_axi_awready) acc++;
    end
    check("aw_blocked_while_bvalid", 32'(acc), 32'd0);
    check("bvalid_held", 32'(s_axi_bvalid), 32'd1);
    axi_read(5'h04, 32'h01, OKAY);
    @(posedge ACLK);
    #1 s_axi_bready = 1'b1;
    wait_aw();
    wait_b();
    axi_read(5'h04, 32'h02, OKAY);

    cycles(5);
    check("rq_drained", 32'(rq.size()), 32'd0);
    check("bq_drained", 32'(bq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
